// File: rtl/dual_sum_checker.sv
// Response-side self-check for the two-result adder: recomputes a+b and c+d,
// compares against the DUT results through a 2-stage pipeline and keeps run statistics.
module dual_sum_checker #(
   parameter int W           = 5,
   parameter int NUM_SAMPLES = 20,
   parameter int CW          = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sample_valid,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [W-1:0]  c,
   input  logic [W-1:0]  d,
   input  logic [W:0]    result1,
   input  logic [W:0]    result2,
   output logic          chk_valid,
   output logic [1:0]    mismatch,
   output logic [CW-1:0] sample_cnt,
   output logic [CW-1:0] err_cnt,
   output logic          first_err_valid,
   output logic [CW-1:0] first_err_idx,
   output logic          busy,
   output logic          done,
   output logic          pass
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);
   localparam logic [CW-1:0] ERR_MAX  = '1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] accCnt_q, accCnt_d;
   logic          drainCnt_q, drainCnt_d;

   logic          s1Valid_q, s1Valid_d;
   logic [W-1:0]  s1A_q, s1B_q, s1C_q, s1D_q;
   logic [W:0]    s1R1_q, s1R2_q;

   logic          chkValid_q, chkValid_d;
   logic [1:0]    mismatch_q, mismatch_d;
   logic [CW-1:0] sampleCnt_q, sampleCnt_d;
   logic [CW-1:0] errCnt_q, errCnt_d;
   logic          firstErrValid_q, firstErrValid_d;
   logic [CW-1:0] firstErrIdx_q, firstErrIdx_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;

   logic          accept;
   logic [W:0]    exp1, exp2;
   logic [1:0]    cmpMismatch;

   assign accept = (state_q == RUN) && sample_valid && !start;

   // Expected sums are formed at W+1 bits so a carry out of the operands is never lost.
   assign exp1        = {1'b0, s1A_q} + {1'b0, s1B_q};
   assign exp2        = {1'b0, s1C_q} + {1'b0, s1D_q};
   assign cmpMismatch = {(s1R2_q != exp2), (s1R1_q != exp1)};

   always_comb begin
      state_d    = state_q;
      accCnt_d   = accCnt_q;
      drainCnt_d = drainCnt_q;
      if (start) begin
         state_d    = RUN;
         accCnt_d   = '0;
         drainCnt_d = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (accept) begin
                  accCnt_d = accCnt_q + 1'b1;
                  if (accCnt_q == LAST_IDX) begin
                     state_d    = DRAIN;
                     drainCnt_d = 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (drainCnt_q) begin
                  state_d = DONE;
               end else begin
                  drainCnt_d = 1'b1;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // start flushes both pipeline stages, so a result already in flight is dropped.
   always_comb begin
      s1Valid_d       = accept;
      chkValid_d      = s1Valid_q && !start;
      mismatch_d      = chkValid_d ? cmpMismatch : mismatch_q;
      sampleCnt_d     = sampleCnt_q;
      errCnt_d        = errCnt_q;
      firstErrValid_d = firstErrValid_q;
      firstErrIdx_d   = firstErrIdx_q;
      if (start) begin
         sampleCnt_d     = '0;
         errCnt_d        = '0;
         firstErrValid_d = 1'b0;
         firstErrIdx_d   = '0;
      end else if (chkValid_d) begin
         sampleCnt_d = sampleCnt_q + 1'b1;
         if (cmpMismatch != 2'b00) begin
            if (errCnt_q != ERR_MAX) begin
               errCnt_d = errCnt_q + 1'b1;
            end
            if (!firstErrValid_q) begin
               firstErrValid_d = 1'b1;
               firstErrIdx_d   = sampleCnt_q;
            end
         end
      end
      done_d = (state_d == DONE);
      pass_d = (state_d == DONE) && (errCnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         accCnt_q        <= '0;
         drainCnt_q      <= 1'b0;
         s1Valid_q       <= 1'b0;
         chkValid_q      <= 1'b0;
         mismatch_q      <= 2'b00;
         sampleCnt_q     <= '0;
         errCnt_q        <= '0;
         firstErrValid_q <= 1'b0;
         firstErrIdx_q   <= '0;
         done_q          <= 1'b0;
         pass_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         accCnt_q        <= accCnt_d;
         drainCnt_q      <= drainCnt_d;
         s1Valid_q       <= s1Valid_d;
         chkValid_q      <= chkValid_d;
         mismatch_q      <= mismatch_d;
         sampleCnt_q     <= sampleCnt_d;
         errCnt_q        <= errCnt_d;
         firstErrValid_q <= firstErrValid_d;
         firstErrIdx_q   <= firstErrIdx_d;
         done_q          <= done_d;
         pass_q          <= pass_d;
      end
   end

   // Operand registers load only on acceptance, keeping idle-cycle X out of the compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1A_q  <= '0;
         s1B_q  <= '0;
         s1C_q  <= '0;
         s1D_q  <= '0;
         s1R1_q <= '0;
         s1R2_q <= '0;
      end else if (accept) begin
         s1A_q  <= a;
         s1B_q  <= b;
         s1C_q  <= c;
         s1D_q  <= d;
         s1R1_q <= result1;
         s1R2_q <= result2;
      end
   end

   assign chk_valid       = chkValid_q;
   assign mismatch        = mismatch_q;
   assign sample_cnt      = sampleCnt_q;
   assign err_cnt         = errCnt_q;
   assign first_err_valid = firstErrValid_q;
   assign first_err_idx   = firstErrIdx_q;
   assign busy            = (state_q == RUN) || (state_q == DRAIN);
   assign done            = done_q;
   assign pass            = pass_q;

endmodule

// File: tb/tb_dual_sum_checker.sv
// Bench for dual_sum_checker: directed and random samples checked against a
// cycle-counting reference model of runs, latency and statistics.
module tb_dual_sum_checker;

   localparam int W   = 5;
   localparam int NUM = 20;
   localparam int CW  = 8;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          sampleValid;
   logic [W-1:0]  aSig, bSig, cSig, dSig;
   logic [W:0]    r1Sig, r2Sig;
   logic          chk_valid;
   logic [1:0]    mismatch;
   logic [CW-1:0] sample_cnt;
   logic [CW-1:0] err_cnt;
   logic          first_err_valid;
   logic [CW-1:0] first_err_idx;
   logic          busy;
   logic          done;
   logic          pass;

   dual_sum_checker #(.W(W), .NUM_SAMPLES(NUM), .CW(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .sample_valid    (sampleValid),
      .a               (aSig),
      .b               (bSig),
      .c               (cSig),
      .d               (dSig),
      .result1         (r1Sig),
      .result2         (r2Sig),
      .chk_valid       (chk_valid),
      .mismatch        (mismatch),
      .sample_cnt      (sample_cnt),
      .err_cnt         (err_cnt),
      .first_err_valid (first_err_valid),
      .first_err_idx   (first_err_idx),
      .busy            (busy),
      .done            (done),
      .pass            (pass)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: a run is a count of accepted samples plus a queue of
   // results due two edges after acceptance.
   int cyc = 0;
   bit mRunning = 0;
   int mAccepted = 0;
   int mLastAccept = 0;
   int mSampleCnt = 0;
   int mErrCnt = 0;
   bit mFirstV = 0;
   int mFirstIdx = 0;
   int dueQ[$];
   int misQ[$];
   bit expChk = 0;
   int expMis = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clearModel(input bit running);
      mRunning   = running;
      mAccepted  = 0;
      mSampleCnt = 0;
      mErrCnt    = 0;
      mFirstV    = 0;
      mFirstIdx  = 0;
      dueQ.delete();
      misQ.delete();
      expChk     = 0;
   endtask

   task automatic checkAll();
      bit finished;
      finished = mRunning && (mAccepted == NUM) && (cyc >= mLastAccept + 2);
      checkOutput("chk_valid", chk_valid, expChk);
      if (expChk) checkOutput("mismatch", mismatch, expMis);
      checkOutput("sample_cnt", sample_cnt, mSampleCnt);
      checkOutput("err_cnt", err_cnt, mErrCnt);
      checkOutput("first_err_valid", first_err_valid, mFirstV);
      if (mFirstV) checkOutput("first_err_idx", first_err_idx, mFirstIdx);
      checkOutput("busy", busy, mRunning && !finished);
      checkOutput("done", done, finished);
      checkOutput("pass", pass, finished && (mErrCnt == 0));
   endtask

   task automatic applyStimulus(input bit st, input bit sv,
                                input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic [W-1:0] ic, input logic [W-1:0] id,
                                input logic [W:0] ir1, input logic [W:0] ir2);
      int e1, e2, mis;
      @(negedge clk);
      start       = st;
      sampleValid = sv;
      aSig = ia; bSig = ib; cSig = ic; dSig = id;
      r1Sig = ir1; r2Sig = ir2;
      @(posedge clk);
      cyc++;
      if (st) begin
         clearModel(1);
      end else if (mRunning && sv && mAccepted < NUM) begin
         e1  = ia + ib;
         e2  = ic + id;
         mis = ((int'(ir2) != e2) ? 2 : 0) | ((int'(ir1) != e1) ? 1 : 0);
         mAccepted++;
         mLastAccept = cyc;
         dueQ.push_back(cyc + 1);
         misQ.push_back(mis);
      end
      expChk = 0;
      if (dueQ.size() > 0 && dueQ[0] == cyc) begin
         void'(dueQ.pop_front());
         expChk = 1;
         expMis = misQ.pop_front();
         if (expMis != 0) begin
            if (!mFirstV) begin
               mFirstV   = 1;
               mFirstIdx = mSampleCnt;
            end
            if (mErrCnt < 255) mErrCnt++;
         end
         mSampleCnt++;
      end
      #1;
      checkAll();
   endtask

   task automatic goodSample();
      logic [W-1:0] ra, rb, rc, rd;
      logic [W:0] s1, s2;
      ra = W'($urandom_range(0, 31)); rb = W'($urandom_range(0, 31));
      rc = W'($urandom_range(0, 31)); rd = W'($urandom_range(0, 31));
      s1 = ra + rb;
      s2 = rc + rd;
      applyStimulus(0, 1, ra, rb, rc, rd, s1, s2);
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 'x, 'x, 'x, 'x, 'x, 'x);
   endtask

   task automatic startPulse();
      applyStimulus(1, 0, 'x, 'x, 'x, 'x, 'x, 'x);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      sampleValid = 1'b0;
      aSig = '0; bSig = '0; cSig = '0; dSig = '0; r1Sig = '0; r2Sig = '0;
      #1;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;

      // Samples before any start are ignored.
      goodSample();
      goodSample();

      // Single correct sample, result visible two cycles after presentation.
      startPulse();
      applyStimulus(0, 1, 5'd3, 5'd4, 5'd31, 5'd31, 6'd7, 6'd62);
      idleCycle();
      checkOutput("tp1_chk_valid", chk_valid, 1);
      checkOutput("tp1_mismatch", mismatch, 2'b00);
      checkOutput("tp1_sample_cnt", sample_cnt, 1);
      idleCycle();

      // Error capture and full-width carry within one run.
      startPulse();
      for (int i = 0; i < NUM; i++) begin
         if (i == 5)       applyStimulus(0, 1, 5'd3, 5'd4, 5'd1, 5'd2, 6'd8, 6'd3);
         else if (i == 9)  applyStimulus(0, 1, 5'd10, 5'd11, 5'd12, 5'd13, 6'd21, 6'd26);
         else if (i == 10) applyStimulus(0, 1, 5'd31, 5'd31, 5'd31, 5'd31, 6'd62, 6'd30);
         else if (i == 11) applyStimulus(0, 1, 5'd31, 5'd31, 5'd31, 5'd31, 6'd62, 6'd62);
         else              goodSample();
         if (i == 6)  checkOutput("err_idx5_mismatch", mismatch, 2'b01);
         if (i == 11) checkOutput("carry_drop_mismatch", mismatch, 2'b10);
         if (i == 12) checkOutput("carry_ok_mismatch", mismatch, 2'b00);
      end
      repeat (3) idleCycle();
      checkOutput("err_run_done", done, 1);
      checkOutput("err_run_err_cnt", err_cnt, 3);
      checkOutput("err_run_first_idx", first_err_idx, 5);
      checkOutput("err_run_pass", pass, 0);

      // 25 correct samples with random gaps: only the first 20 count.
      startPulse();
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 2) == 0) idleCycle();
         goodSample();
      end
      repeat (3) idleCycle();
      checkOutput("len_sample_cnt", sample_cnt, NUM);
      checkOutput("len_pass", pass, 1);

      // Restart mid-run with a sample presented in the start cycle.
      startPulse();
      repeat (7) goodSample();
      applyStimulus(1, 1, 5'd1, 5'd1, 5'd1, 5'd1, 6'd2, 6'd2);
      checkOutput("restart_sample_cnt", sample_cnt, 0);
      repeat (NUM) goodSample();
      repeat (3) idleCycle();
      checkOutput("restart_done", done, 1);

      // Asynchronous reset in the middle of DRAIN.
      startPulse();
      repeat (NUM) goodSample();
      idleCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_chk_valid", chk_valid, 0);
      checkOutput("rst_sample_cnt", sample_cnt, 0);
      checkOutput("rst_mismatch", mismatch, 0);
      checkOutput("rst_done", done, 0);
      clearModel(0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) goodSample();
      startPulse();
      goodSample();
      repeat (2) idleCycle();
      checkOutput("post_rst_sample_cnt", sample_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
